// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback with a memory ready/request handshake and illegal-op trap.
module mc_maindec #(
  parameter bit EN_BNE = 1'b1,
  parameter bit EN_ORI = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branchne,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12,
    ORIEX   = 4'd13,
    ILLEGAL = 4'd15
  } state_t;

  state_t cur, nxt;

  assign state = cur;

  // State register; reset aborts any instruction in flight and restarts at fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  // Next-state and Moore decode; only the fetch strobes also see mem_ready,
  // so the PC advances exactly once per fetch however long memory stalls.
  always_comb begin
    nxt      = FETCH;
    mem_req  = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchne = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    zeroext  = 1'b0;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    illegal  = 1'b0;
    case (cur)
      FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        nxt     = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'b000000: nxt = RTYPEEX;
          6'b100011: nxt = MEMADR;
          6'b101011: nxt = MEMADR;
          6'b000100: nxt = BEQEX;
          6'b001000: nxt = ADDIEX;
          6'b000010: nxt = JEX;
          6'b000101: nxt = EN_BNE ? BNEEX : ILLEGAL;
          6'b001101: nxt = EN_ORI ? ORIEX : ILLEGAL;
          default:   nxt = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = (op == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        nxt     = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        nxt      = mem_ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        nxt     = RTYPEWB;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      BNEEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branchne = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = IMMWB;
      end
      ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
        zeroext = 1'b1;
        nxt     = IMMWB;
      end
      IMMWB: regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      ILLEGAL: illegal = 1'b1;
      default: nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Self-checking bench for mc_maindec: a route-per-opcode model checks both a
// full-featured instance and one with bne/ori disabled on every cycle.
module tb_mc_maindec;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;

  logic       d1_mem_req, d1_iord, d1_irwrite, d1_pcwrite, d1_branch, d1_branchne;
  logic       d1_memwrite, d1_regwrite, d1_regdst, d1_memtoreg, d1_alusrca;
  logic       d1_zeroext, d1_illegal;
  logic [1:0] d1_alusrcb, d1_pcsrc, d1_aluop;
  logic [3:0] d1_state;

  logic       d2_mem_req, d2_iord, d2_irwrite, d2_pcwrite, d2_branch, d2_branchne;
  logic       d2_memwrite, d2_regwrite, d2_regdst, d2_memtoreg, d2_alusrca;
  logic       d2_zeroext, d2_illegal;
  logic [1:0] d2_alusrcb, d2_pcsrc, d2_aluop;
  logic [3:0] d2_state;

  int errors = 0;
  int checks = 0;

  int pos1 = 0;
  int pos2 = 0;
  logic [63:0] trace1, trace2;
  int ncyc, pcwCount, rwCount, ill1Count, ill2Count;

  always #5 clk = ~clk;

  mc_maindec #(.EN_BNE(1'b1), .EN_ORI(1'b1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(d1_mem_req), .iord(d1_iord), .irwrite(d1_irwrite), .pcwrite(d1_pcwrite),
    .branch(d1_branch), .branchne(d1_branchne), .memwrite(d1_memwrite),
    .regwrite(d1_regwrite), .regdst(d1_regdst), .memtoreg(d1_memtoreg),
    .alusrca(d1_alusrca), .alusrcb(d1_alusrcb), .zeroext(d1_zeroext),
    .pcsrc(d1_pcsrc), .aluop(d1_aluop), .illegal(d1_illegal), .state(d1_state)
  );

  mc_maindec #(.EN_BNE(1'b0), .EN_ORI(1'b0)) dut2 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(d2_mem_req), .iord(d2_iord), .irwrite(d2_irwrite), .pcwrite(d2_pcwrite),
    .branch(d2_branch), .branchne(d2_branchne), .memwrite(d2_memwrite),
    .regwrite(d2_regwrite), .regdst(d2_regdst), .memtoreg(d2_memtoreg),
    .alusrca(d2_alusrca), .alusrcb(d2_alusrcb), .zeroext(d2_zeroext),
    .pcsrc(d2_pcsrc), .aluop(d2_aluop), .illegal(d2_illegal), .state(d2_state)
  );

  wire [18:0] act1 = {d1_mem_req, d1_iord, d1_irwrite, d1_pcwrite, d1_branch, d1_branchne,
                      d1_memwrite, d1_regwrite, d1_regdst, d1_memtoreg, d1_alusrca,
                      d1_alusrcb, d1_zeroext, d1_pcsrc, d1_aluop, d1_illegal};
  wire [18:0] act2 = {d2_mem_req, d2_iord, d2_irwrite, d2_pcwrite, d2_branch, d2_branchne,
                      d2_memwrite, d2_regwrite, d2_regdst, d2_memtoreg, d2_alusrca,
                      d2_alusrcb, d2_zeroext, d2_pcsrc, d2_aluop, d2_illegal};

  // Each instruction is a fixed list of states after fetch/decode, zero-terminated.
  function automatic logic [27:0] route3(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c);
    return {4'h0, 4'h0, c, b, a, 4'h1, 4'h0};
  endfunction

  function automatic logic [27:0] routeOf(input logic [5:0] o, input bit enb, input bit eno);
    case (o)
      6'b000000: return route3(4'd6, 4'd7, 4'd0);
      6'b100011: return route3(4'd2, 4'd3, 4'd4);
      6'b101011: return route3(4'd2, 4'd5, 4'd0);
      6'b000100: return route3(4'd8, 4'd0, 4'd0);
      6'b001000: return route3(4'd9, 4'd10, 4'd0);
      6'b000010: return route3(4'd11, 4'd0, 4'd0);
      6'b000101: return enb ? route3(4'd12, 4'd0, 4'd0) : route3(4'd15, 4'd0, 4'd0);
      6'b001101: return eno ? route3(4'd13, 4'd10, 4'd0) : route3(4'd15, 4'd0, 4'd0);
      default:   return route3(4'd15, 4'd0, 4'd0);
    endcase
  endfunction

  function automatic logic [3:0] stateAt(input int p, input logic [5:0] o, input bit enb,
                                         input bit eno);
    logic [27:0] r;
    r = routeOf(o, enb, eno);
    return r[p*4 +: 4];
  endfunction

  function automatic int advance(input int p, input logic [5:0] o, input logic r,
                                 input bit enb, input bit eno);
    logic [3:0] s;
    int np;
    s = stateAt(p, o, enb, eno);
    if ((s == 4'd0 || s == 4'd3 || s == 4'd5) && !r) return p;
    np = p + 1;
    if (stateAt(np, o, enb, eno) == 4'd0) np = 0;
    return np;
  endfunction

  // Control word each state must present, from the state's role in the datapath.
  function automatic logic [18:0] expOut(input logic [3:0] s, input logic r);
    logic mr, io, irw, pcw, br, bn, mw, rw, rd, m2r, sa, ze, il;
    logic [1:0] sb, ps, ao;
    {mr, io, irw, pcw, br, bn, mw, rw, rd, m2r, sa, ze, il} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (s)
      4'd0:  begin mr = 1; sb = 2'b01; irw = r; pcw = r; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; io = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mr = 1; io = 1; mw = 1; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
      4'd9:  begin sa = 1; sb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin ps = 2'b10; pcw = 1; end
      4'd12: begin sa = 1; ao = 2'b01; ps = 2'b01; bn = 1; end
      4'd13: begin sa = 1; sb = 2'b10; ao = 2'b11; ze = 1; end
      4'd15: il = 1;
      default: ;
    endcase
    return {mr, io, irw, pcw, br, bn, mw, rw, rd, m2r, sa, sb, ze, ps, ao, il};
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] e1, e2;
    e1 = stateAt(pos1, op, 1'b1, 1'b1);
    e2 = stateAt(pos2, op, 1'b0, 1'b0);
    compare("dut1_state", {60'd0, d1_state}, {60'd0, e1});
    compare("dut1_ctrl", {45'd0, act1}, {45'd0, expOut(e1, mem_ready)});
    compare("dut2_state", {60'd0, d2_state}, {60'd0, e2});
    compare("dut2_ctrl", {45'd0, act2}, {45'd0, expOut(e2, mem_ready)});
  endtask

  // One clock of stimulus: drive, check mid-cycle, clock, advance the model.
  task automatic applyStimulus(input logic [5:0] o, input logic r);
    op = o;
    mem_ready = r;
    #1;
    checkOutput();
    trace1 = {trace1[59:0], d1_state};
    trace2 = {trace2[59:0], d2_state};
    ncyc++;
    if (d1_pcwrite) pcwCount++;
    if (d1_regwrite) rwCount++;
    if (d1_illegal) ill1Count++;
    if (d2_illegal) ill2Count++;
    @(posedge clk);
    pos1 = advance(pos1, o, r, 1'b1, 1'b1);
    pos2 = advance(pos2, o, r, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic resetPulse();
    reset = 1'b1;
    #1;
    pos1 = 0;
    pos2 = 0;
    checkOutput();
    compare("reset_state", {60'd0, d1_state}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    trace1 = '0; trace2 = '0;
    ncyc = 0; pcwCount = 0; rwCount = 0; ill1Count = 0; ill2Count = 0;
  endtask

  // Run one instruction on dut1 from fetch back to fetch, stalling memory as asked.
  task automatic runInstr(input logic [5:0] o, input int fw, input int mw);
    int fc, mc;
    bit left;
    logic r;
    logic [3:0] s;
    fc = 0; mc = 0; left = 0;
    resetPulse();
    while (!(left && pos1 == 0) && ncyc < 40) begin
      s = stateAt(pos1, o, 1'b1, 1'b1);
      if (s == 4'd0) begin r = (fc < fw) ? 1'b0 : 1'b1; fc++; end
      else if (s == 4'd3 || s == 4'd5) begin r = (mc < mw) ? 1'b0 : 1'b1; mc++; end
      else r = 1'($urandom_range(0, 1));
      applyStimulus(o, r);
      if (pos1 != 0) left = 1;
    end
    if (ncyc >= 40) compare("instr_timeout", 64'(ncyc), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    op = 6'b000000;
    mem_ready = 1'b0;
    trace1 = '0; trace2 = '0;
    ncyc = 0; pcwCount = 0; rwCount = 0; ill1Count = 0; ill2Count = 0;
    @(negedge clk);

    runInstr(6'b000000, 0, 0);
    compare("rtype_trace", trace1, 64'h0167);
    compare("rtype_cycles", 64'(ncyc), 64'd4);
    compare("rtype_pcwrite", 64'(pcwCount), 64'd1);

    runInstr(6'b100011, 2, 3);
    compare("lw_trace", trace1, 64'h0001233334);
    compare("lw_cycles", 64'(ncyc), 64'd10);
    compare("lw_pcwrite", 64'(pcwCount), 64'd1);
    compare("lw_regwrite", 64'(rwCount), 64'd1);

    runInstr(6'b101011, 0, 0);
    compare("sw_trace", trace1, 64'h0125);
    compare("sw_regwrite", 64'(rwCount), 64'd0);

    runInstr(6'b000100, 0, 0);
    compare("beq_trace", trace1, 64'h018);
    compare("beq_cycles", 64'(ncyc), 64'd3);

    runInstr(6'b001000, 0, 0);
    compare("addi_trace", trace1, 64'h019A);

    runInstr(6'b000010, 0, 0);
    compare("j_trace", trace1, 64'h01B);

    runInstr(6'b000101, 0, 0);
    compare("bne_trace", trace1, 64'h01C);
    compare("bne_off_trace", trace2, 64'h01F);
    compare("bne_off_illegal", 64'(ill2Count), 64'd1);
    compare("bne_on_illegal", 64'(ill1Count), 64'd0);

    runInstr(6'b001101, 0, 0);
    compare("ori_trace", trace1, 64'h01DA);
    compare("ori_off_trace", trace2, 64'h01F0);

    runInstr(6'b111111, 0, 0);
    compare("bad_op_trace", trace1, 64'h01F);
    compare("bad_op_illegal", 64'(ill1Count), 64'd1);

    // Abort a store while it is waiting on memory.
    resetPulse();
    applyStimulus(6'b101011, 1'b1);
    applyStimulus(6'b101011, 1'b1);
    applyStimulus(6'b101011, 1'b1);
    op = 6'b101011;
    mem_ready = 1'b0;
    #1;
    checkOutput();
    compare("memwr_strobe_before", {63'd0, d1_memwrite}, 64'd1);
    reset = 1'b1;
    #1;
    compare("memwr_strobe_abort", {63'd0, d1_memwrite}, 64'd0);
    compare("memwr_abort_state", {60'd0, d1_state}, 64'd0);
    pos1 = 0;
    pos2 = 0;
    checkOutput();
    @(negedge clk);
    reset = 1'b0;

    runInstr(6'b000000, 0, 0);
    compare("recover_trace", trace1, 64'h0167);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_maindec.md
# mc_maindec

Multicycle main controller for the MIPS core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback steps, driving the shared-memory multicycle datapath. It replaces the single-cycle opcode decoder. It adds three things: a memory ready/request handshake, optional `bne` and `ori` support selected by parameter, and an illegal-opcode trap. The ALU decoder, PC-enable logic (`pcwrite | branch&zero | branchne&~zero`) and datapath sit outside this block.

## Interface
- `EN_BNE`, default 1: 1 decodes op 000101 (`bne`); 0 treats it as illegal.
- `EN_ORI`, default 1: 1 decodes op 001101 (`ori`); 0 treats it as illegal.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; forces FETCH immediately.
- `op`  in  6  opcode from instruction register; stable from DECODE until FETCH.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory access requested (FETCH, MEMRD, MEMWR).
- `iord`  out  1  0 = address from PC, 1 = address from ALUOut.
- `irwrite`  out  1  load instruction register.
- `pcwrite`  out  1  unconditional PC write.
- `branch`  out  1  PC write if zero.
- `branchne`  out  1  PC write if not zero.
- `memwrite`  out  1  store strobe.
- `regwrite`  out  1  register-file write.
- `regdst`  out  1  1 = rd, 0 = rt.
- `memtoreg`  out  1  1 = data register, 0 = ALUOut.
- `alusrca`  out  1  0 = PC, 1 = register A.
- `alusrcb`  out  2  00 = B, 01 = constant 4, 10 = SignImm (or ZeroImm), 11 = SignImm<<2.
- `zeroext`  out  1  immediate is zero-extended.
- `pcsrc`  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `aluop`  out  2  00 = add, 01 = sub, 10 = funct, 11 = or.
- `illegal`  out  1  unsupported opcode trap pulse.
- `state`  out  4  current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, IMMWB=10, JEX=11, BNEEX=12, ORIEX=13, ILLEGAL=15.
- All outputs default to 0. Each state asserts only the outputs listed below.
- FETCH: mem_req=1, alusrcb=01, irwrite=pcwrite=mem_ready. Goes to DECODE when mem_ready=1, otherwise holds.
- DECODE: alusrcb=11. Next state by `op`:
  - 000000 goes to RTYPEEX.
  - 100011 and 101011 go to MEMADR.
  - 000100 goes to BEQEX.
  - 001000 goes to ADDIEX.
  - 000010 goes to JEX.
  - 000101 goes to BNEEX if EN_BNE, else ILLEGAL.
  - 001101 goes to ORIEX if EN_ORI, else ILLEGAL.
  - Any other opcode goes to ILLEGAL.
- MEMADR: alusrca=1, alusrcb=10. Goes to MEMRD if op=100011, else MEMWR.
- MEMRD: mem_req=1, iord=1. Goes to MEMWB on mem_ready, otherwise holds.
- MEMWB: regwrite=1, memtoreg=1. Goes to FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Goes to FETCH on mem_ready, otherwise holds.
- RTYPEEX: alusrca=1, aluop=10. Goes to RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1. Goes to FETCH.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1. Goes to FETCH.
- BNEEX: same as BEQEX but branchne=1 instead of branch=1. Goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10. Goes to IMMWB.
- ORIEX: alusrca=1, alusrcb=10, aluop=11, zeroext=1. Goes to IMMWB.
- IMMWB: regwrite=1. Goes to FETCH.
- JEX: pcsrc=10, pcwrite=1. Goes to FETCH.
- ILLEGAL: illegal=1 for exactly one cycle. Goes to FETCH.
- State register codes 14 and 15 are not reachable except 15 = ILLEGAL. Any unreachable code goes to FETCH on the next edge.

## Timing
- Reset: the state register is FETCH asynchronously. Outputs are then mem_req=1, alusrcb=01, irwrite=pcwrite=mem_ready, all others 0.
- Releasing reset produces no spurious strobes.
- Reset asserted mid-instruction aborts the instruction. All write strobes drop combinationally with the state change.
- Outputs are combinational decodes of the state register only. The exceptions are irwrite and pcwrite in FETCH, which are also gated by mem_ready. This guarantees exactly one PC increment per fetch regardless of wait states.
- The memory handshake completes on the edge where mem_req=1 and mem_ready=1. mem_ready is ignored in every other state.
- mem_req stays high continuously through wait states. iord and memwrite are held stable throughout.
- Latency with zero wait states:
  - lw: 5 cycles.
  - sw, R-type, addi, ori: 4 cycles.
  - beq, bne, j: 3 cycles.
  - illegal: 3 cycles.
- Each wait cycle on a memory access adds 1 cycle.

## Test plan
- Reset, then mem_ready=1 constant with op=000000 → state sequence 0,1,6,7,0. regwrite=1 and regdst=1 only in state 7. pcwrite=1 only in state 0.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD → FETCH held 3 cycles with pcwrite pulsing once. MEMRD held 4 cycles with iord=1 and mem_req=1. MEMWB asserts regwrite=1 and memtoreg=1.
- sw (101011) → sequence 0,1,2,5,0. memwrite=1 only in state 5. regwrite is never 1.
- EN_BNE=1 with op=000101 → state 12 with branchne=1, aluop=01, pcsrc=01. EN_BNE=0 with same op → state 15, illegal=1 for one cycle, then FETCH.
- EN_ORI=1 with op=001101 → states 13 then 10. zeroext=1 and aluop=11 in state 13. regwrite=1, regdst=0 in state 10.
- Assert reset asynchronously mid-MEMWR with memwrite=1 → memwrite drops before the next clock edge and state reads 0. op=111111 → ILLEGAL then FETCH.
